// File: rtl/sba_pkg.sv
// sba_pkg: shared SBA types and constants for SBA initiators
package sba_pkg;
    typedef enum logic [2:0] {IDLE, RD, GAP_R, WR, GAP_W, DONE, ERR} state_t;
    localparam logic [3:0] SBA_WE_WORD = 4'hF;
    localparam logic [3:0] SBA_WE_READ = 4'h0;
    localparam int SBA_ADDR_W = 32;
    localparam int SBA_DATA_W = 32;
endpackage

// File: rtl/sba_dma_if.sv
// sba_dma_if: SBA initiator/responder bus bundle
interface sba_dma_if
    import sba_pkg::*;
();
    logic [SBA_ADDR_W-1:0] o_addr;
    logic [SBA_DATA_W-1:0] o_dat_w;
    logic [3:0]            o_we;
    logic                  o_stb;
    logic [SBA_DATA_W-1:0] i_dat_r;
    logic                  i_ack;
    modport master (output o_addr, o_dat_w, o_we, o_stb, input i_dat_r, i_ack);
    modport slave (input o_addr, o_dat_w, o_we, o_stb, output i_dat_r, i_ack);
endinterface

// File: rtl/sba_ack_timer.sv
// sba_ack_timer: flags a strobe that has waited TIMEOUT cycles without an ack
module sba_ack_timer #(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);
    logic [TMO_W-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt <= '0;
        else if (i_clr) cnt <= '0;
        else if (i_run) cnt <= cnt + TMO_W'(1);
    end
    // fires on the cycle whose increment would reach TIMEOUT; an ack in that cycle drops i_run
    assign o_expired = i_run && (cnt == TMO_W'(TIMEOUT - 1));
endmodule

// File: rtl/sba_dma.sv
// sba_dma: SBA bus initiator that copies or fills blocks of 32-bit words
module sba_dma
    import sba_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [SBA_ADDR_W-1:0] i_src,
    input  logic [SBA_ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]      i_len,
    input  logic [SBA_DATA_W-1:0] i_fill,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [LEN_W-1:0]      o_count,
    sba_dma_if.master             bus
);
    state_t                state, nxt;
    logic                  mode, err, stb, expired;
    logic [SBA_ADDR_W-1:0] src, dst, off;
    logic [SBA_DATA_W-1:0] fill, data;
    logic [LEN_W-1:0]      len, n, n_inc;

    sba_ack_timer #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (!stb),
        .i_run     (stb && !bus.i_ack),
        .o_expired (expired)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (i_start) nxt = (i_len == '0) ? DONE : (i_mode ? WR : RD);
            RD:      nxt = bus.i_ack ? GAP_R : (expired ? ERR : RD);
            GAP_R:   nxt = WR;
            WR:      nxt = bus.i_ack ? ((n_inc == len) ? DONE : GAP_W) : (expired ? ERR : WR);
            GAP_W:   nxt = mode ? WR : RD;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        stb         = (state == RD) || (state == WR);
        n_inc       = n + LEN_W'(1);
        off         = SBA_ADDR_W'({n, 2'b00});
        bus.o_stb   = stb;
        bus.o_addr  = (state == RD) ? src + off : (state == WR) ? dst + off : '0;
        bus.o_we    = (state == WR) ? SBA_WE_WORD : SBA_WE_READ;
        bus.o_dat_w = (state == WR) ? (mode ? fill : data) : '0;
        o_busy      = state != IDLE;
        o_done      = state == DONE;
        o_err       = err;
        o_count     = n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            mode  <= 1'b0;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            fill  <= '0;
            data  <= '0;
            n     <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && i_start) begin
                mode <= i_mode;
                src  <= {i_src[SBA_ADDR_W-1:2], 2'b00};
                dst  <= {i_dst[SBA_ADDR_W-1:2], 2'b00};
                len  <= i_len;
                fill <= i_fill;
                n    <= '0;
                err  <= 1'b0;
            end
            if (state == RD && bus.i_ack) data <= bus.i_dat_r;
            if (state == WR && bus.i_ack) n <= n_inc;
            if (nxt == ERR) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sba_dma.sv
// tb_sba_dma: random and directed transfers checked against a word-level model
module tb_sba_dma;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, mode = 1'b0;
    logic [31:0] src = '0, dst = '0, fill = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [15:0] count;

    sba_dma_if bus();

    sba_dma #(.LEN_W(16), .TIMEOUT(TIMEOUT), .TMO_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_mode  (mode),
        .i_src   (src),
        .i_dst   (dst),
        .i_len   (len),
        .i_fill  (fill),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err),
        .o_count (count),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    logic [31:0] init_mem [1024];
    logic [31:0] ref_mem [1024];
    logic        load = 1'b0;

    function automatic bit mapped(input logic [31:0] a);
        return a[31:12] == 20'h10000;
    endfunction

    // 1-cycle-latency responder; 0x1000_0xxx is mapped, everything else never acks
    always @(posedge clk) begin
        if (load) mem <= init_mem;
        if (!rst_n) begin
            bus.i_ack <= 1'b0;
            bus.i_dat_r <= '0;
        end else begin
            bus.i_ack <= bus.o_stb && !bus.i_ack && mapped(bus.o_addr);
            if (bus.o_stb && !bus.i_ack) bus.i_dat_r <= mem[bus.o_addr[11:2]];
            if (bus.o_stb && bus.i_ack && bus.o_we == 4'hF) mem[bus.o_addr[11:2]] <= bus.o_dat_w;
        end
    end

    int rd_cnt = 0, wr_cnt = 0, stb_cyc = 0, viol = 0;
    logic p_stb = 1'b0, p_ack = 1'b0;
    logic [67:0] p_bus = '0;
    always @(negedge clk) begin
        if (p_stb && p_ack && bus.o_stb) viol <= viol + 1;
        else if (p_stb && !p_ack && bus.o_stb && {bus.o_addr, bus.o_we, bus.o_dat_w} != p_bus) viol <= viol + 1;
        if (bus.o_stb && !p_stb) begin
            if (bus.o_we == 4'hF) wr_cnt <= wr_cnt + 1;
            else rd_cnt <= rd_cnt + 1;
        end
        if (bus.o_stb) stb_cyc <= stb_cyc + 1;
        p_stb <= bus.o_stb;
        p_ack <= bus.i_ack;
        p_bus <= {bus.o_addr, bus.o_we, bus.o_dat_w};
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_mem();
        int nbad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem", nbad, 0);
    endtask

    task automatic xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] l, input logic [31:0] f, input bit poke);
        int k = 0, per = m ? 3 : 6, sc = 0, nrd = 0, nwr = 0, extra = 0, cyc = 1, lim;
        int b_rd = rd_cnt, b_wr = wr_cnt, b_sc = stb_cyc, b_v = viol;
        bit e = 0;
        logic [31:0] sa, da, v;
        for (int i = 0; i < int'(l); i++) begin
            sa = {s[31:2], 2'b00} + 32'(4 * i);
            da = {d[31:2], 2'b00} + 32'(4 * i);
            v = f;
            if (!m) begin
                nrd++;
                if (!mapped(sa)) begin
                    e = 1; sc += TIMEOUT; extra = TIMEOUT + 1;
                    break;
                end
                v = ref_mem[sa[11:2]];
                sc += 2;
            end
            nwr++;
            if (!mapped(da)) begin
                e = 1; sc += TIMEOUT; extra = (m ? 0 : 3) + TIMEOUT + 1;
                break;
            end
            ref_mem[da[11:2]] = v;
            sc += 2;
            k++;
        end
        lim = 6 * int'(l) + TIMEOUT + 20;
        mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_clr", err, 0);
        while (!done && !err && cyc < lim) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 5) begin
                src = $urandom; dst = $urandom; len = 16'd1; mode = ~m; fill = $urandom;
            end
            start = poke && cyc == 5;
        end
        start = 1'b0;
        chk("cycles", cyc, e ? k * per + extra : (l == 0 ? 1 : per * int'(l)));
        chk("done", done, !e);
        chk("err", err, e);
        chk("count", count, k);
        @(negedge clk);
        chk("idle", {busy, done}, 0);
        chk("err_hold", err, e);
        chk("rd_strobes", rd_cnt - b_rd, nrd);
        chk("wr_strobes", wr_cnt - b_wr, nwr);
        chk("stb_cycles", stb_cyc - b_sc, sc);
        chk("protocol", viol - b_v, 0);
        chk_mem();
    endtask

    task automatic rst_mid();
        int cyc = 0;
        ref_mem[256] = ref_mem[0];
        mode = 1'b0; src = 32'h1000_0000; dst = 32'h1000_0400; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(bus.o_stb && bus.o_we == 4'hF && count == 16'd1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach", cyc < 100, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {bus.o_stb, busy, count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", {busy, done, err}, 0);
        chk_mem();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) init_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) init_mem[i] = 32'h1111_1111 * (i + 1);
        ref_mem = init_mem;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {busy, done, err, count}, 0);
        chk("rst_bus", {bus.o_stb, bus.o_we, bus.o_addr, bus.o_dat_w}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 32'h1000_0000, 32'h1000_0100, 16'd4, 32'h0, 1'b0);
        xfer(1'b1, 32'h0, 32'h1000_0200, 16'd3, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b0, 32'h1000_0000, 32'h1000_0300, 16'd0, 32'h0, 1'b0);
        xfer(1'b1, 32'h0, 32'h3000_0000, 16'd3, 32'hCAFE_F00D, 1'b0);
        xfer(1'b1, 32'h0, 32'h1000_0300, 16'd2, 32'h1234_5678, 1'b0);
        xfer(1'b0, 32'h1000_0000, 32'h1000_0380, 16'd4, 32'h0, 1'b1);
        rst_mid();
        xfer(1'b0, 32'h1000_0000, 32'h1000_0500, 16'd4, 32'h0, 1'b0);
        xfer(1'b0, 32'h1000_0FF8, 32'h1000_0600, 16'd4, 32'h0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            logic [31:0] s = 32'h1000_0000 + 4 * $urandom_range(0, 511) + $urandom_range(0, 3);
            logic [31:0] d = 32'h1000_0000 + 4 * $urandom_range(0, 511) + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) d = 32'h2000_0000 + 4 * $urandom_range(0, 15);
            xfer(1'($urandom), s, d, 16'($urandom_range(0, 12)), $urandom, 1'($urandom_range(0, 3) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
